// File: rtl/ex_unit_pipe.sv
// Registered RV32 execute stage: register file, MEM/WB forwarding, ALU, branch
// compare and an optional iterative multiply/divide unit behind a valid/ready handshake.
module ex_unit_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned HAS_MULDIV = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] imm,
  input  logic [3:0]      op,
  input  logic [6:0]      opcode,
  input  logic            is_m,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_res,
  input  logic            mem_fwd_valid,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_res,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic [XLEN-1:0] x2,
  output logic [4:0]      rd_out,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned RIW = $clog2(NREGS);
  localparam int unsigned CW  = $clog2(XLEN);

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [XLEN-1:0]       r_regs [NREGS];
  logic                  r_out_valid;
  logic [XLEN-1:0]       r_res, r_x2;
  logic [4:0]            r_rd;
  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_f3;
  logic [XLEN-1:0]       r_a, r_op1, r_md_x2;
  logic [2*XLEN-1:0]     r_p;
  logic                  r_neg, r_rneg, r_dz, r_ovf;
  logic [4:0]            r_md_rd;

  logic [XLEN-1:0]       w_op1, w_rs2, w_op2, w_alu, w_res_c, w_md_res;
  logic [SHW-1:0]        w_shamt;
  logic [3:0]            w_alu_op;
  logic                  w_taken, w_accept, w_is_md;
  logic                  w_s1, w_s2, w_n1, w_n2;
  logic [XLEN-1:0]       w_mag1, w_mag2;
  logic [XLEN:0]         w_mul_sum, w_div_sh, w_div_diff;
  logic [2*XLEN-1:0]     w_p_nxt, w_prod;
  logic [XLEN-1:0]       w_quo, w_rem;

  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_is_md   = (HAS_MULDIV != 0) && is_m && (opcode == OP_REG);
  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign x2        = r_x2;
  assign rd_out    = r_rd;
  assign busy      = (r_state == S_CALC);

  // Operand fetch: x0, then MEM forward, then WB bypass, then register file
  always_comb begin
    w_op1 = '0;
    if (rs1 == 5'd0)                         w_op1 = '0;
    else if (mem_fwd_valid && mem_rd == rs1) w_op1 = mem_res;
    else if (wb_we && wb_rd == rs1)          w_op1 = wb_res;
    else if (32'(rs1) < NREGS)               w_op1 = r_regs[RIW'(rs1)];
    w_rs2 = '0;
    if (rs2 == 5'd0)                         w_rs2 = '0;
    else if (mem_fwd_valid && mem_rd == rs2) w_rs2 = mem_res;
    else if (wb_we && wb_rd == rs2)          w_rs2 = wb_res;
    else if (32'(rs2) < NREGS)               w_rs2 = r_regs[RIW'(rs2)];
  end

  always_comb begin
    w_op2 = w_rs2;
    if (opcode == OP_IMM || opcode == OP_LUI || opcode == OP_JALR ||
        opcode == OP_LOAD || opcode == OP_STORE)
      w_op2 = imm;
  end

  // ALU, branch compare and result select for single-cycle ops
  always_comb begin
    w_shamt  = w_op2[SHW-1:0];
    w_alu_op = (opcode == OP_IMM && op == 4'b1000) ? 4'b0000 : op;
    w_alu    = w_op1 + w_op2;
    case (w_alu_op)
      4'b1000: w_alu = w_op1 - w_op2;
      4'b0001: w_alu = w_op1 << w_shamt;
      4'b0010: w_alu = XLEN'($signed(w_op1) < $signed(w_op2));
      4'b0011: w_alu = XLEN'(w_op1 < w_op2);
      4'b0100: w_alu = w_op1 ^ w_op2;
      4'b0101: w_alu = w_op1 >> w_shamt;
      4'b1101: w_alu = $signed(w_op1) >>> w_shamt;
      4'b0110: w_alu = w_op1 | w_op2;
      4'b0111: w_alu = w_op1 & w_op2;
      default: w_alu = w_op1 + w_op2;
    endcase
    w_taken = 1'b0;
    case (op[2:0])
      3'b000:  w_taken = (w_op1 == w_op2);
      3'b001:  w_taken = (w_op1 != w_op2);
      3'b100:  w_taken = ($signed(w_op1) <  $signed(w_op2));
      3'b101:  w_taken = ($signed(w_op1) >= $signed(w_op2));
      3'b110:  w_taken = (w_op1 <  w_op2);
      3'b111:  w_taken = (w_op1 >= w_op2);
      default: w_taken = 1'b0;
    endcase
    w_res_c = imm;
    case (opcode)
      OP_IMM:                     w_res_c = w_alu;
      OP_REG:                     w_res_c = is_m ? (w_op1 + w_op2) : w_alu;
      OP_BR:                      w_res_c = XLEN'(w_taken);
      OP_LOAD, OP_STORE, OP_JALR: w_res_c = w_op1 + imm;
      default:                    w_res_c = imm;
    endcase
  end

  // Mul/div operand conditioning and one-bit-per-cycle iteration step
  always_comb begin
    w_s1   = op[2] ? !op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    w_s2   = op[2] ? !op[0] : (op[1:0] == 2'b01);
    w_n1   = w_s1 && w_op1[XLEN-1];
    w_n2   = w_s2 && w_rs2[XLEN-1];
    w_mag1 = w_n1 ? -w_op1 : w_op1;
    w_mag2 = w_n2 ? -w_rs2 : w_rs2;
    w_mul_sum  = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_a} : '0);
    w_div_sh   = r_p[2*XLEN-1:XLEN-1];
    w_div_diff = w_div_sh - {1'b0, r_a};
    if (!r_f3[2])
      w_p_nxt = {w_mul_sum, r_p[XLEN-1:1]};
    else if (!w_div_diff[XLEN])
      w_p_nxt = {w_div_diff[XLEN-1:0], r_p[XLEN-2:0], 1'b1};
    else
      w_p_nxt = {w_div_sh[XLEN-1:0], r_p[XLEN-2:0], 1'b0};
    w_prod = r_neg  ? -r_p : r_p;
    w_quo  = r_neg  ? -r_p[XLEN-1:0] : r_p[XLEN-1:0];
    w_rem  = r_rneg ? -r_p[2*XLEN-1:XLEN] : r_p[2*XLEN-1:XLEN];
    if (!r_f3[2])    w_md_res = (r_f3 == 3'b000) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else if (r_dz)   w_md_res = r_f3[1] ? r_op1 : '1;
    else if (r_ovf)  w_md_res = r_f3[1] ? '0 : r_op1;
    else             w_md_res = r_f3[1] ? w_rem : w_quo;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept && w_is_md) w_state_nxt = S_CALC;
        S_CALC:  if (r_cnt == CW'(XLEN-1)) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
    end else if (wb_we && wb_rd != 5'd0 && 32'(wb_rd) < NREGS) begin
      r_regs[RIW'(wb_rd)] <= wb_res;
    end
  end

  // Output register and mul/div working state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_x2        <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_f3        <= '0;
      r_a         <= '0;
      r_op1       <= '0;
      r_md_x2     <= '0;
      r_md_rd     <= '0;
      r_p         <= '0;
      r_neg       <= 1'b0;
      r_rneg      <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept && !w_is_md) begin
        r_out_valid <= 1'b1;
        r_res       <= w_res_c;
        r_x2        <= w_rs2;
        r_rd        <= rd;
      end else if (r_state == S_DONE) begin
        r_out_valid <= 1'b1;
        r_res       <= w_md_res;
        r_x2        <= r_md_x2;
        r_rd        <= r_md_rd;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept && w_is_md) begin
        r_cnt   <= '0;
        r_f3    <= op[2:0];
        r_op1   <= w_op1;
        r_md_x2 <= w_rs2;
        r_md_rd <= rd;
        r_neg   <= w_n1 ^ w_n2;
        r_rneg  <= w_n1;
        r_dz    <= (w_rs2 == '0);
        r_ovf   <= !op[0] && (w_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (w_rs2 == '1);
        r_a     <= op[2] ? w_mag2 : w_mag1;
        r_p     <= {{XLEN{1'b0}}, (op[2] ? w_mag1 : w_mag2)};
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + 1'b1;
        r_p   <= w_p_nxt;
      end
    end
  end

endmodule

// File: doc/ex_unit_pipe.md
Name: ex_unit_pipe

Overview:
- Parametrised, registered execute stage for the RV32 pipeline. Successor to the combinational EX stage.
- Contains the integer register file, MEM/WB operand forwarding, the ALU, branch compare and an optional iterative M-extension multiply/divide unit.
- Sits between decode and MEM.
- Adds a valid/ready handshake, a registered output, flush, and variable XLEN/register count.

Parameters:
- XLEN, 32, datapath width (≥8, power of two).
- NREGS, 32, architectural registers (32 = RV32I, 16 = RV32E).
- HAS_MULDIV, 1, 1 instantiates the iterative MUL/DIV unit; 0 treats is_m ops as ADD/SUB-class ALU ops.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  discard the in-flight/held result
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- rs1, rs2, rd  in  5 each  register indices
- imm  in  XLEN  sign-extended immediate
- op  in  4  {funct7[5], funct3}
- opcode  in  7  RISC-V major opcode
- is_m  in  1  funct7 = 0000001 (M extension)
- wb_we  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_res  in  XLEN  writeback data
- mem_fwd_valid  in  1  MEM stage holds a forwardable result
- mem_rd  in  5  MEM-stage destination
- mem_res  in  XLEN  MEM-stage result
- out_valid  out  1  result register valid
- out_ready  in  1  MEM stage consumes the result
- res  out  XLEN  result / address / branch-taken flag
- x2  out  XLEN  forwarded rs2 (store data)
- rd_out  out  5  destination of the held result
- busy  out  1  MUL/DIV iteration in progress

Behaviour:
- Reset (async, reset_n=0):
  - out_valid=0, res=0, x2=0, rd_out=0, busy=0.
  - FSM to IDLE; all registers cleared to 0.
- Register file:
  - Write on posedge when wb_we=1, wb_rd≠0 and wb_rd<NREGS.
  - Reads of index 0 or ≥NREGS return 0.
- Operand select, per source, priority order:
  1. x0 → 0.
  2. mem_fwd_valid and mem_rd match → mem_res.
  3. wb_we and wb_rd match → wb_res.
  4. Otherwise the register file.
- Op2 selection:
  - imm for IMM_OP (0010011), LUI (0110111), JALR (1100111), LOAD (0000011), STORE (0100011).
  - Forwarded rs2 otherwise.
  - x2 always carries forwarded rs2.
- ALU (IMM_OP/REG_OP), op encoding:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - Shift amount is Op2[log2(XLEN)-1:0].
  - For IMM_OP, encoding 1000 computes ADD.
- Branch (1100011), res = {XLEN-1 zeros, taken}:
  - BEQ 000, BNE 001, BLT 100 (signed).
  - BGE 101: signed ≥, equal operands are taken.
  - BLTU 110 (unsigned <).
  - BGEU 111: unsigned ≥.
- Other opcodes:
  - LOAD/STORE/JALR: res=Op1+imm.
  - LUI/AUIPC/JAL and any other: res=imm.
- Handshake:
  - in_ready = FSM IDLE and (!out_valid or out_ready).
  - Accept = in_valid and in_ready. Operands are sampled at accept.
- Single-cycle ops: result registered at the accept edge; out_valid=1 the next cycle.
- Output hold: res/x2/rd_out/out_valid are held stable until out_ready=1 while out_valid=1.
- MUL/DIV (HAS_MULDIV=1, is_m=1, opcode REG_OP):
  - funct3 decode: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
  - FSM IDLE→CALC on accept; busy=1 in CALC.
  - Shift-add multiply or restoring divide, one bit per cycle, counter 0..XLEN-1.
  - CALC→DONE after XLEN cycles; DONE loads the result register, sets out_valid, returns to IDLE.
  - Fixed latency: out_valid rises XLEN+1 cycles after the accept edge.
  - Signed ops work on magnitudes, then fix the sign.
  - Divide by zero: quotient all-ones, remainder = dividend.
  - Overflow (most-negative / −1): quotient = dividend, remainder 0.
- Flush:
  - At the next edge, out_valid→0 and the FSM returns to IDLE (busy=0).
  - Any accept in the same cycle is suppressed.
  - The register file is unaffected.
- Writeback coincidence: a WB write and a forwarded read in the same cycle deliver wb_res (bypass), not the stale register.
- Reset mid-MUL/DIV: abort immediately, all outputs at reset values.

Test Plan:
- Forwarding priority: reg x5=10; mem_fwd_valid=1, mem_rd=5, mem_res=20; wb_we=1, wb_rd=5, wb_res=30; ADD x5+x0 → res=20. Drop mem_fwd_valid → res=30.
- Branch boundary: x1=x2=7. BGE → res=1; BGEU → res=1; BLT → res=0. x1=0xFFFFFFFF, x2=1: BLT → 1, BLTU → 0.
- Backpressure: issue ADD 3+4 with out_ready=0. Required: res=7 held, in_ready=0 for 5 cycles. out_ready=1 → next instruction accepted that cycle.
- MUL/DIV latency (XLEN=32):
  - MULH 0x80000000×0x80000000 → res=0x40000000 exactly 33 cycles after accept; busy high 32 cycles.
  - DIV 0x80000000/−1 → res=0x80000000.
  - DIVU 5/0 → res=0xFFFFFFFF; REM 5/0 → res=5.
- Flush mid-DIV: accept DIVU, assert flush at cycle 10. Required: busy=0, out_valid stays 0, in_ready=1 next cycle.
- Async reset and RV32E: pull reset_n low mid-CALC → outputs 0 immediately. With NREGS=16: write x20=9, then read x20 → 0.
